// File: rtl/mod_4_if.sv
`default_nettype none
// ============================================================================
// Module      : mod_4_if
// Description : Operand/result bundle for the modulo-4 reducer.
//               A   - unsigned operand, driven by the master.
//               OUT - registered residue, driven by the slave (mod_4).
// Revision    : 1.0 - initial release
// ============================================================================
interface mod_4_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] OUT;

  modport master (output A, input OUT);
  modport slave  (input A, output OUT);
endinterface
`default_nettype wire

// File: rtl/mod_4.sv
`default_nettype none
// ============================================================================
// Module      : mod_4
// Description : Registered modulo-4 reducer. Each rising clk edge samples A
//               and presents A mod 4, zero-extended, on OUT one cycle later.
//               The residue is a plain bit-select of A[1:0]; no divider.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset, clears OUT
//               bus   - mod_4_if slave modport (A in, OUT out)
// Revision    : 1.0 - initial release
// ============================================================================
module mod_4 #(
  parameter int WIDTH = 4
) (
  input  wire    clk,
  input  wire    rst_n,
  mod_4_if.slave bus
);

  // Only the two residue bits are stored; the upper bits of OUT are tied to
  // zero so they stay zero through reset and in every cycle.
  logic [1:0] residue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      residue <= 2'b00;
    end else begin
      residue <= bus.A[1:0];
    end
  end

  generate
    if (WIDTH > 2) begin : g_wide
      assign bus.OUT = {{(WIDTH-2){1'b0}}, residue};
      // Upper operand bits do not influence a mod-4 result.
      wire unused_upper = &{1'b0, bus.A[WIDTH-1:2]};
    end else begin : g_narrow
      assign bus.OUT = residue;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mod_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_4
// Description : Self-checking bench for mod_4 (WIDTH = 4). Table-driven
//               sweep plus hand-written reset, glitch and hold sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mod_4_if #(.WIDTH(4)) bus ();

  mod_4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: OUT=%b required %b at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Sweep 0..7 then the upper range 8, 11, 13, 15.
    vecs[0]  = '{4'd0,  4'd0};
    vecs[1]  = '{4'd1,  4'd1};
    vecs[2]  = '{4'd2,  4'd2};
    vecs[3]  = '{4'd3,  4'd3};
    vecs[4]  = '{4'd4,  4'd0};
    vecs[5]  = '{4'd5,  4'd1};
    vecs[6]  = '{4'd6,  4'd2};
    vecs[7]  = '{4'd7,  4'd3};
    vecs[8]  = '{4'd8,  4'd0};
    vecs[9]  = '{4'd11, 4'd3};
    vecs[10] = '{4'd13, 4'd1};
    vecs[11] = '{4'd15, 4'd3};

    // Reset held low with clock running.
    rst_n = 1'b0;
    bus.A = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", bus.OUT, 4'b0000);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("reset_release", bus.OUT, 4'b0011);

    // Table sweep: drive on negedge, check one edge later.
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      bus.A = vecs[i].a;
      @(posedge clk);
      @(negedge clk);
      check("sweep", bus.OUT, vecs[i].exp);
      check("upper_zero", {bus.OUT[3:2], 2'b00}, 4'b0000);
    end

    // Asynchronous reset mid-stream.
    bus.A = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    check("pre_async", bus.OUT, 4'b0010);
    #2 rst_n = 1'b0;
    #1 check("async_reset", bus.OUT, 4'b0000);
    bus.A = 4'b0101;
    @(posedge clk);
    #1 check("async_held", bus.OUT, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("async_release", bus.OUT, 4'b0001);

    // Glitch inside one low phase must not reach OUT.
    @(negedge clk);
    bus.A = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    check("glitch_pre", bus.OUT, 4'b0001);
    #1 bus.A = 4'b0110;
    #1 bus.A = 4'b0001;
    @(posedge clk);
    #1 check("glitch_immune", bus.OUT, 4'b0001);

    // Clean change: visible exactly one edge later, not before.
    @(negedge clk);
    bus.A = 4'b0110;
    #2 check("latency_before", bus.OUT, 4'b0001);
    @(posedge clk);
    #1 check("latency_after", bus.OUT, 4'b0010);

    // Hold constant operand for ten cycles.
    @(negedge clk);
    bus.A = 4'b1110;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold", bus.OUT, 4'b0010);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
